// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: line-format encodings, error
// bit positions, receive-entry layout, FSM state types and the configuration
// record that moves from the host shadow to the receiver.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receive FIFO entry: {frame_err, parity_err, data[8:0]}
    localparam int DATA_W  = 9;
    localparam int ENTRY_W = 11;
    // Level counter is sized for the largest supported DEPTH (64)
    localparam int LEVEL_W = 7;

    // Parity encodings
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Data-bit encodings (5..9 data bits)
    localparam logic [2:0] DBITS_5 = 3'b000;
    localparam logic [2:0] DBITS_6 = 3'b001;
    localparam logic [2:0] DBITS_7 = 3'b010;
    localparam logic [2:0] DBITS_8 = 3'b011;
    localparam logic [2:0] DBITS_9 = 3'b100;

    // Error bit indices inside rx_error / err_sticky
    localparam int ERR_FRAME   = 2;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 0;

    typedef enum logic {
        CFG_ACTIVE  = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_FIRED = 2'd2
    } to_state_e;

    typedef struct packed {
        logic        rx_en;
        logic [1:0]  parity;
        logic [2:0]  data_bits;
        logic        stop_bit;
        logic        fifo_en;
        logic [15:0] divisor;
    } rx_cfg_t;

    // Builds a FIFO entry; the overrun flag is not stored per entry.
    function automatic logic [ENTRY_W-1:0] make_entry(input logic [2:0]        err,
                                                      input logic [DATA_W-1:0] data);
        return {err[ERR_FRAME], err[ERR_PARITY], data};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous receive FIFO with occupancy count and flush.
//   clk, rst            clock, asynchronous active-high reset
//   depth               effective capacity (1..DEPTH); DEPTH when FIFO mode on
//   push, push_data     write request and entry
//   pop                 read request
//   flush               empty the FIFO; beats same-cycle push/pop
//   push_ok, pop_ok     accepted write / read this cycle
//   overrun             write rejected because the FIFO was full
//   rd_data, rd_valid   popped entry, valid for one cycle after the pop
//   level               current entry count
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] depth,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic               push_ok,
    output logic               pop_ok,
    output logic               overrun,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a pop. An empty FIFO never forwards a
    // same-cycle push to the reader.
    always_comb begin
        pop_ok  = pop && (level != '0) && !flush;
        push_ok = push && !flush && ((level < depth) || pop_ok);
        overrun = push && !flush && !push_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rptr];
            end
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                // Pointers wrap naturally at DEPTH (power of two)
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop_ok)  rptr <= rptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage carries no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Host-side controller for a UART receiver: shadowed configuration that is
// applied only while the line is idle, receive FIFO, sticky errors, idle
// timeout and interrupt generation.
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_wr, cfg_*            requested configuration, captured into a shadow
//   cfg_thresh, cfg_timeout  level irq threshold / idle timeout (0 = off)
//   rx_en..rx_divisor        active configuration driven to the receiver
//   rx_idle, rx_done         receiver status; rx_done strobes a new frame
//   rx_data, rx_error        frame data and {frame, parity, overrun}
//   fifo_full, rx_data_read  receiver-side flow indications
//   rd_req, rd_data, rd_valid host pop interface
//   flush, err_clr           FIFO flush, sticky error clear
//   level, cfg_pending, err_sticky, irq  status
//   dbg_cfg_state, dbg_to_state          FSM state visibility
//
// Host read handshake: rd_req is a single-cycle request; when the FIFO holds
// at least one entry at that edge, rd_data is updated and rd_valid pulses high
// for exactly one cycle after it. A request against an empty FIFO is dropped
// and produces no rd_valid.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter logic [15:0] DIV_RST = 16'd5208
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic               cfg_rx_en,
    input  logic [1:0]         cfg_parity,
    input  logic [2:0]         cfg_data_bits,
    input  logic               cfg_stop_bit,
    input  logic               cfg_fifo_en,
    input  logic [15:0]        cfg_divisor,
    input  logic [3:0]         cfg_thresh,
    input  logic [7:0]         cfg_timeout,
    output logic               rx_en,
    output logic [1:0]         parity,
    output logic [2:0]         data_bits,
    output logic               stop_bit,
    output logic               fifo_en,
    output logic [15:0]        rx_divisor,
    input  logic               rx_idle,
    input  logic               rx_done,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic [2:0]         rx_error,
    output logic               fifo_full,
    output logic               rx_data_read,
    input  logic               rd_req,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               flush,
    input  logic               err_clr,
    output logic [LEVEL_W-1:0] level,
    output logic               cfg_pending,
    output logic [2:0]         err_sticky,
    output logic               irq,
    output logic               dbg_cfg_state,
    output logic [1:0]         dbg_to_state
);

    localparam rx_cfg_t CFG_RESET = '{
        rx_en:     1'b0,
        parity:    PAR_NONE,
        data_bits: DBITS_8,
        stop_bit:  1'b0,
        fifo_en:   1'b0,
        divisor:   DIV_RST
    };

    // ---------------------------------------------------------------- config
    cfg_state_e cfg_state, cfg_state_nxt;
    rx_cfg_t    shadow, active, cfg_req;
    logic       apply;

    assign cfg_req = '{
        rx_en:     cfg_rx_en,
        parity:    cfg_parity,
        data_bits: cfg_data_bits,
        stop_bit:  cfg_stop_bit,
        fifo_en:   cfg_fifo_en,
        divisor:   cfg_divisor
    };

    // Apply uses the shadow as it stood before this edge; a cfg_wr in the
    // same cycle refreshes the shadow and keeps the request pending.
    always_comb begin
        cfg_state_nxt = cfg_state;
        apply         = 1'b0;
        case (cfg_state)
            CFG_ACTIVE: begin
                if (cfg_wr) cfg_state_nxt = CFG_PENDING;
            end
            CFG_PENDING: begin
                if (rx_idle) begin
                    apply = 1'b1;
                    if (!cfg_wr) cfg_state_nxt = CFG_ACTIVE;
                end
            end
            default: cfg_state_nxt = CFG_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_state <= CFG_ACTIVE;
            shadow    <= CFG_RESET;
            active    <= CFG_RESET;
        end else begin
            cfg_state <= cfg_state_nxt;
            if (apply)  active <= shadow;
            if (cfg_wr) shadow <= cfg_req;
        end
    end

    assign rx_en       = active.rx_en;
    assign parity      = active.parity;
    assign data_bits   = active.data_bits;
    assign stop_bit    = active.stop_bit;
    assign fifo_en     = active.fifo_en;
    assign rx_divisor  = active.divisor;
    assign cfg_pending = (cfg_state == CFG_PENDING);

    // ------------------------------------------------------------------ FIFO
    logic [LEVEL_W-1:0] depth;
    logic               push_ok, pop_ok, overrun;

    // With FIFO mode off the storage degenerates to a single holding register
    assign depth = active.fifo_en ? LEVEL_W'(DEPTH) : LEVEL_W'(1);

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .depth    (depth),
        .push     (rx_done),
        .push_data(make_entry(rx_error, rx_data)),
        .pop      (rd_req),
        .flush    (flush),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok),
        .overrun  (overrun),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level)
    );

    assign fifo_full    = (level == depth);
    assign rx_data_read = active.fifo_en ? 1'b1 : (level == '0);

    // --------------------------------------------------------- sticky errors
    // Overrun covers both a dropped entry here and one reported by the
    // receiver itself. A flushed frame contributes nothing.
    logic [2:0] err_set;

    always_comb begin
        err_set              = '0;
        err_set[ERR_FRAME]   = push_ok & rx_error[ERR_FRAME];
        err_set[ERR_PARITY]  = push_ok & rx_error[ERR_PARITY];
        err_set[ERR_OVERRUN] = overrun | (rx_done & !flush & rx_error[ERR_OVERRUN]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= '0;
        end else begin
            // A new error in the clearing cycle survives the clear
            err_sticky <= (err_clr ? 3'b000 : err_sticky) | err_set;
        end
    end

    // --------------------------------------------------------------- timeout
    to_state_e   to_state, to_state_nxt;
    logic [15:0] div_cnt, div_cnt_nxt;
    logic [7:0]  tick_cnt, tick_cnt_nxt;
    logic        bit_tick, activity, to_stop;

    // One bit time = rx_divisor clocks; a divisor of 0 ticks every clock
    assign bit_tick = ({1'b0, div_cnt} + 17'd1) >= {1'b0, rx_divisor};
    assign activity = push_ok | pop_ok;
    assign to_stop  = flush || (level == '0) || (cfg_timeout == 8'd0);

    always_comb begin
        to_state_nxt = to_state;
        div_cnt_nxt  = div_cnt;
        tick_cnt_nxt = tick_cnt;
        case (to_state)
            T_IDLE: begin
                div_cnt_nxt  = '0;
                tick_cnt_nxt = '0;
                if (!to_stop) to_state_nxt = T_COUNT;
            end
            T_COUNT: begin
                if (to_stop) begin
                    to_state_nxt = T_IDLE;
                end else if (activity) begin
                    div_cnt_nxt  = '0;
                    tick_cnt_nxt = '0;
                end else if (bit_tick) begin
                    div_cnt_nxt = '0;
                    if (({1'b0, tick_cnt} + 9'd1) >= {1'b0, cfg_timeout}) begin
                        to_state_nxt = T_FIRED;
                        tick_cnt_nxt = '0;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 8'd1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 16'd1;
                end
            end
            T_FIRED: begin
                if (to_stop) begin
                    to_state_nxt = T_IDLE;
                end else if (activity) begin
                    to_state_nxt = T_COUNT;
                    div_cnt_nxt  = '0;
                    tick_cnt_nxt = '0;
                end
            end
            default: to_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_state <= T_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            to_state <= to_state_nxt;
            div_cnt  <= div_cnt_nxt;
            tick_cnt <= tick_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------- irq
    logic irq_nxt;

    assign irq_nxt = ((cfg_thresh != 4'd0) && (level >= {3'b000, cfg_thresh}))
                   || (to_state == T_FIRED)
                   || (err_sticky != 3'b000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_nxt;
        end
    end

    assign dbg_cfg_state = cfg_state;
    assign dbg_to_state  = to_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed scenarios followed by a randomized run, checked against a queue
// based reference model of the receive controller.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    // {rx_en, parity[1:0], data_bits[2:0], stop_bit, fifo_en, divisor[15:0]}
    localparam logic [23:0] RESET_CFG = {1'b0, 2'b00, 3'b011, 1'b0, 1'b0, 16'd5208};
    localparam logic [23:0] CFG_8E1   = {1'b1, 2'b01, 3'b011, 1'b0, 1'b1, 16'd434};
    localparam logic [23:0] CFG_HOLD  = {1'b1, 2'b01, 3'b011, 1'b0, 1'b0, 16'd434};
    localparam logic [23:0] CFG_TO    = {1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 16'd16};
    localparam logic [23:0] CFG_ALT   = {1'b1, 2'b10, 3'b100, 1'b1, 1'b1, 16'd27};

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cfg_wr, cfg_rx_en, cfg_stop_bit, cfg_fifo_en;
    logic [1:0]  cfg_parity;
    logic [2:0]  cfg_data_bits;
    logic [15:0] cfg_divisor;
    logic [3:0]  cfg_thresh;
    logic [7:0]  cfg_timeout;
    logic        rx_en, stop_bit, fifo_en;
    logic [1:0]  parity;
    logic [2:0]  data_bits;
    logic [15:0] rx_divisor;
    logic        rx_idle, rx_done;
    logic [8:0]  rx_data;
    logic [2:0]  rx_error;
    logic        fifo_full, rx_data_read, rd_req, rd_valid, flush, err_clr;
    logic [10:0] rd_data;
    logic [6:0]  level;
    logic        cfg_pending, irq, dbg_cfg_state;
    logic [2:0]  err_sticky;
    logic [1:0]  dbg_to_state;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_RST(16'd5208)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr(cfg_wr), .cfg_rx_en(cfg_rx_en), .cfg_parity(cfg_parity),
        .cfg_data_bits(cfg_data_bits), .cfg_stop_bit(cfg_stop_bit),
        .cfg_fifo_en(cfg_fifo_en), .cfg_divisor(cfg_divisor),
        .cfg_thresh(cfg_thresh), .cfg_timeout(cfg_timeout),
        .rx_en(rx_en), .parity(parity), .data_bits(data_bits),
        .stop_bit(stop_bit), .fifo_en(fifo_en), .rx_divisor(rx_divisor),
        .rx_idle(rx_idle), .rx_done(rx_done), .rx_data(rx_data), .rx_error(rx_error),
        .fifo_full(fifo_full), .rx_data_read(rx_data_read),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .err_clr(err_clr), .level(level),
        .cfg_pending(cfg_pending), .err_sticky(err_sticky), .irq(irq),
        .dbg_cfg_state(dbg_cfg_state), .dbg_to_state(dbg_to_state)
    );

    // ------------------------------------------------------------ scoreboard
    logic [10:0] exp_q[$];
    logic [2:0]  m_sticky;
    logic [10:0] m_rd_data;
    logic        m_rd_valid, m_irq, m_pending;
    logic [23:0] m_act, m_shadow;
    int          n_vec = 0;
    int          n_err = 0;

    wire [23:0] act_obs = {rx_en, parity, data_bits, stop_bit, fifo_en, rx_divisor};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sticky   = 3'b000;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_irq      = 1'b0;
        m_pending  = 1'b0;
        m_act      = RESET_CFG;
        m_shadow   = RESET_CFG;
    endtask

    task automatic check_all();
        int cap;
        cap = m_act[16] ? DEPTH : 1;
        chk("level",        32'(level),        exp_q.size());
        chk("fifo_full",    32'(fifo_full),    32'(exp_q.size() == cap));
        chk("rx_data_read", 32'(rx_data_read), m_act[16] ? 32'd1 : 32'(exp_q.size() == 0));
        chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        chk("rd_data",      32'(rd_data),      32'(m_rd_data));
        chk("err_sticky",   32'(err_sticky),   32'(m_sticky));
        chk("irq",          32'(irq),          32'(m_irq));
        chk("cfg_pending",  32'(cfg_pending),  32'(m_pending));
        chk("active_cfg",   32'(act_obs),      32'(m_act));
    endtask

    // One clock: derive the model's next state from the inputs presented in
    // this cycle, then let the DUT take the edge.
    task automatic cycle();
        int         cap, sz;
        bit         popped;
        logic [2:0] set_err;
        logic       irq_next;
        sz       = exp_q.size();
        cap      = m_act[16] ? DEPTH : 1;
        irq_next = ((cfg_thresh != 0) && (sz >= int'(cfg_thresh))) || (m_sticky != 3'b000);
        set_err  = 3'b000;
        popped   = 0;
        m_rd_valid = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (rd_req && sz > 0) begin
                m_rd_data  = exp_q.pop_front();
                m_rd_valid = 1'b1;
                popped     = 1;
            end
            if (rx_done) begin
                if (rx_error[0]) set_err[0] = 1'b1;
                if (sz < cap || popped) begin
                    exp_q.push_back({rx_error[2], rx_error[1], rx_data});
                    set_err[2] = rx_error[2];
                    set_err[1] = rx_error[1];
                end else begin
                    set_err[0] = 1'b1;
                end
            end
        end
        m_sticky = (err_clr ? 3'b000 : m_sticky) | set_err;
        if (m_pending && rx_idle) begin
            m_act     = m_shadow;
            m_pending = 1'b0;
        end
        if (cfg_wr) begin
            m_shadow  = {cfg_rx_en, cfg_parity, cfg_data_bits, cfg_stop_bit, cfg_fifo_en, cfg_divisor};
            m_pending = 1'b1;
        end
        m_irq = irq_next;
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic set_cfg(input logic [23:0] v);
        {cfg_rx_en, cfg_parity, cfg_data_bits, cfg_stop_bit, cfg_fifo_en, cfg_divisor} = v;
    endtask

    task automatic idle_inputs();
        cfg_wr = 0; rx_done = 0; rd_req = 0; flush = 0; err_clr = 0;
        rx_data = '0; rx_error = '0;
    endtask

    task automatic push(input logic [8:0] d);
        rx_done = 1; rx_data = d; rx_error = 3'b000;
        cycle();
        rx_done = 0;
        check_all();
    endtask

    // Write a configuration with the line idle: capture, then apply
    task automatic write_cfg(input logic [23:0] v);
        set_cfg(v); cfg_wr = 1;
        cycle(); cfg_wr = 0; check_all();
        cycle(); check_all();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_inputs();
        set_cfg(RESET_CFG);
        cfg_thresh = 4'd0; cfg_timeout = 8'd0; rx_idle = 1'b1;
        model_reset();

        // Reset state
        @(posedge clk); #1;
        check_all();
        chk("reset_to_state", 32'(dbg_to_state), 32'd0);
        rst = 1'b0;
        cycle(); check_all();

        // Config held while the receiver is busy, applied once idle
        rx_idle = 0;
        set_cfg(CFG_8E1); cfg_wr = 1;
        cycle(); cfg_wr = 0; check_all();
        chk("cfg_pending_busy", 32'(cfg_pending), 32'd1);
        chk("cfg_unchanged",    32'(act_obs), 32'(RESET_CFG));
        repeat (3) begin cycle(); check_all(); end
        rx_idle = 1;
        cycle(); check_all();
        chk("cfg_applied",      32'(act_obs), 32'(CFG_8E1));
        chk("cfg_pending_done", 32'(cfg_pending), 32'd0);

        // Overwrite while pending, and a write in the apply cycle
        rx_idle = 0;
        set_cfg(CFG_ALT); cfg_wr = 1; cycle(); check_all();
        set_cfg(CFG_8E1); rx_idle = 1; cycle(); cfg_wr = 0; check_all();
        chk("apply_keeps_pending", 32'(cfg_pending), 32'd1);
        chk("apply_old_shadow",    32'(act_obs), 32'(CFG_ALT));
        cycle(); check_all();
        chk("apply_new_shadow",    32'(act_obs), 32'(CFG_8E1));

        // 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) push(9'($urandom_range(0, 511)));
        chk("full_level",   32'(level), 32'd16);
        chk("full_flag",    32'(fifo_full), 32'd1);
        chk("full_overrun", 32'(err_sticky), 32'd1);

        // Simultaneous pop and push at full
        rd_req = 1; rx_done = 1; rx_data = 9'h1C3;
        cycle(); rd_req = 0; rx_done = 0; check_all();
        chk("pp_level",  32'(level), 32'd16);
        chk("pp_sticky", 32'(err_sticky), 32'd1);

        err_clr = 1; cycle(); err_clr = 0; check_all();
        chk("err_cleared", 32'(err_sticky), 32'd0);

        // Flush beats a same-cycle push at level 5
        flush = 1; cycle(); flush = 0; check_all();
        for (int i = 0; i < 5; i++) push(9'($urandom_range(0, 511)));
        flush = 1; rx_done = 1; rx_data = 9'h0FF;
        cycle(); flush = 0; rx_done = 0; check_all();
        chk("flush_level",  32'(level), 32'd0);
        chk("flush_sticky", 32'(err_sticky), 32'd0);

        // Holding-register mode
        write_cfg(CFG_HOLD);
        push(9'h0A5);
        chk("hold_not_read", 32'(rx_data_read), 32'd0);
        push(9'h15A);
        chk("hold_level",   32'(level), 32'd1);
        chk("hold_overrun", 32'(err_sticky), 32'd1);
        rd_req = 1; cycle(); rd_req = 0; check_all();
        chk("hold_rd_data", 32'(rd_data), 32'h0A5);
        chk("hold_read",    32'(rx_data_read), 32'd1);
        err_clr = 1; cycle(); err_clr = 0; check_all();

        // Idle timeout: 4 bit times at 16 clocks per bit
        write_cfg(CFG_TO);
        cfg_timeout = 8'd4;
        rx_done = 1; rx_data = 9'h033; cycle(); rx_done = 0;
        n = 0;
        while (n < 100 && irq !== 1'b1) begin
            cycle();
            n++;
        end
        chk("timeout_delay", 32'((n >= 64) && (n <= 67)), 32'd1);
        rd_req = 1; cycle(); rd_req = 0;
        cycle(); cycle();
        chk("timeout_irq_clr", 32'(irq), 32'd0);
        chk("timeout_idle",    32'(dbg_to_state), 32'd0);
        cfg_timeout = 8'd0;
        check_all();

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++) push(9'($urandom_range(0, 511)));
        rx_idle = 0; set_cfg(CFG_ALT); cfg_wr = 1; cycle(); cfg_wr = 0; check_all();
        rx_done = 1; rx_error = 3'b110; rx_data = 9'h111;
        #2 rst = 1'b1;
        #1 idle_inputs();
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0; rx_idle = 1;
        check_all();
        chk("rst_to_state", 32'(dbg_to_state), 32'd0);
        cycle(); check_all();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rx_done  = ($urandom_range(0, 99) < 45);
            rx_data  = 9'($urandom_range(0, 511));
            rx_error = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            rd_req   = ($urandom_range(0, 99) < 40);
            flush    = ($urandom_range(0, 99) < 3);
            err_clr  = ($urandom_range(0, 99) < 6);
            rx_idle  = ($urandom_range(0, 99) < 70);
            cfg_wr   = ($urandom_range(0, 99) < 4);
            if (cfg_wr) set_cfg({1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                                 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 16'($urandom_range(1, 600))});
            if ($urandom_range(0, 99) < 3) cfg_thresh = 4'($urandom_range(0, 15));
            cycle();
            check_all();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
